// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU operation encodings and default widths.
// No logic; constants only.
// No flow control.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1011;
    localparam logic [3:0] ALU_NOP = 4'b1111;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: MEM result, else WB data, else registered value.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] regval,
    input  logic              mem_regwrite,
    input  logic [REG_W-1:0]  mem_writereg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_writereg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd
);

    logic mem_hit;
    logic wb_hit;

    // $zero is hard-wired, so a write to it never supplies a value
    assign mem_hit = mem_regwrite && (mem_writereg != '0) && (mem_writereg == src);
    assign wb_hit  = wb_regwrite  && (wb_writereg  != '0) && (wb_writereg  == src);

    // Younger producer (MEM) wins over older (WB)
    always_comb begin
        fwd = regval;
        if (FWD_EN && mem_hit) begin
            fwd = mem_data;
        end else if (FWD_EN && wb_hit) begin
            fwd = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use stall, bubble insertion and EX operand forwarding.
// Latency: one cycle from ID fields to ALU inputs; a load-use costs one bubble.
// Backpressure: ExHold freezes all state; Stall holds PC and IF/ID.
module id_ex_stage import mips_pkg::*; #(
    parameter int         DATA_W  = DEF_DATA_W,
    parameter int         REG_W   = DEF_REG_W,
    parameter bit         FWD_EN  = 1'b1,
    parameter logic [3:0] NOP_CTL = ALU_NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IdValid,
    input  logic [DATA_W-1:0] IdRsData,
    input  logic [DATA_W-1:0] IdRtData,
    input  logic [REG_W-1:0]  IdRs,
    input  logic [REG_W-1:0]  IdRt,
    input  logic [REG_W-1:0]  IdWriteReg,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [4:0]        IdShamt,
    input  logic [3:0]        IdALUCtl,
    input  logic              IdALUSrc,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdMemToReg,
    input  logic              Flush,
    input  logic              ExHold,
    input  logic              MemRegWrite,
    input  logic [REG_W-1:0]  MemWriteReg,
    input  logic [DATA_W-1:0] MemALUOut,
    input  logic              WbRegWrite,
    input  logic [REG_W-1:0]  WbWriteReg,
    input  logic [DATA_W-1:0] WbData,
    output logic              Stall,
    output logic [3:0]        ALUCtl,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [4:0]        Shamt,
    output logic [DATA_W-1:0] ExStoreData,
    output logic              ExValid,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic              ExMemWrite,
    output logic              ExMemToReg,
    output logic [REG_W-1:0]  ExWriteReg
);

    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_alusrc;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              load_use;
    logic              bubble;
    logic              wb_byp_rs;
    logic              wb_byp_rt;

    // Load in EX whose destination feeds the ID instruction; rt is compared even for I-type
    assign load_use = ExValid && ExMemRead && (ExWriteReg != '0) &&
                      ((ExWriteReg == IdRs) || (ExWriteReg == IdRt));
    assign Stall    = !reset && IdValid && !Flush && load_use;
    assign bubble   = Flush || Stall || !IdValid;

    // Register file is not write-before-read, so WB is bypassed into the captured operands
    assign wb_byp_rs = WbRegWrite && (WbWriteReg != '0) && (WbWriteReg == IdRs);
    assign wb_byp_rt = WbRegWrite && (WbWriteReg != '0) && (WbWriteReg == IdRt);

    // Control path: cleared on reset or bubble so nothing downstream commits
    always_ff @(posedge clk) begin
        if (reset) begin
            ExValid    <= 1'b0;
            ExRegWrite <= 1'b0;
            ExMemRead  <= 1'b0;
            ExMemWrite <= 1'b0;
            ExMemToReg <= 1'b0;
            ALUCtl     <= NOP_CTL;
        end else if (!ExHold) begin
            ExValid    <= !bubble;
            ExRegWrite <= !bubble && IdRegWrite;
            ExMemRead  <= !bubble && IdMemRead;
            ExMemWrite <= !bubble && IdMemWrite;
            ExMemToReg <= !bubble && IdMemToReg;
            ALUCtl     <= bubble ? NOP_CTL : IdALUCtl;
        end
    end

    // Data path: only loaded for real instructions; contents during a bubble are don't-care
    always_ff @(posedge clk) begin
        if (reset) begin
            ExWriteReg <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            Shamt      <= '0;
            ex_alusrc  <= 1'b0;
        end else if (!ExHold && !bubble) begin
            ExWriteReg <= IdWriteReg;
            ex_rs      <= IdRs;
            ex_rt      <= IdRt;
            ex_rs_data <= wb_byp_rs ? WbData : IdRsData;
            ex_rt_data <= wb_byp_rt ? WbData : IdRtData;
            ex_imm     <= IdImm;
            Shamt      <= IdShamt;
            ex_alusrc  <= IdALUSrc;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_rs (
        .src          (ex_rs),
        .regval       (ex_rs_data),
        .mem_regwrite (MemRegWrite),
        .mem_writereg (MemWriteReg),
        .mem_data     (MemALUOut),
        .wb_regwrite  (WbRegWrite),
        .wb_writereg  (WbWriteReg),
        .wb_data      (WbData),
        .fwd          (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_rt (
        .src          (ex_rt),
        .regval       (ex_rt_data),
        .mem_regwrite (MemRegWrite),
        .mem_writereg (MemWriteReg),
        .mem_data     (MemALUOut),
        .wb_regwrite  (WbRegWrite),
        .wb_writereg  (WbWriteReg),
        .wb_data      (WbData),
        .fwd          (fwd_rt)
    );

    assign A           = fwd_rs;
    assign B           = ex_alusrc ? ex_imm : fwd_rt;
    assign ExStoreData = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random stimulus for id_ex_stage against an instruction-level reference model.
// Checks each cycle at the falling edge, plus explicit scenario checks after rising edges.
// Summary line reports total checks and errors.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          IdValid;
    logic [DW-1:0] IdRsData, IdRtData, IdImm;
    logic [RW-1:0] IdRs, IdRt, IdWriteReg;
    logic [4:0]    IdShamt;
    logic [3:0]    IdALUCtl;
    logic          IdALUSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
    logic          Flush, ExHold;
    logic          MemRegWrite;
    logic [RW-1:0] MemWriteReg;
    logic [DW-1:0] MemALUOut;
    logic          WbRegWrite;
    logic [RW-1:0] WbWriteReg;
    logic [DW-1:0] WbData;
    logic          Stall;
    logic [3:0]    ALUCtl;
    logic [DW-1:0] A, B, ExStoreData;
    logic [4:0]    Shamt;
    logic          ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg;
    logic [RW-1:0] ExWriteReg;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .FWD_EN(1'b1), .NOP_CTL(4'b1111)) dut (
        .clk(clk), .reset(reset), .IdValid(IdValid),
        .IdRsData(IdRsData), .IdRtData(IdRtData), .IdRs(IdRs), .IdRt(IdRt),
        .IdWriteReg(IdWriteReg), .IdImm(IdImm), .IdShamt(IdShamt), .IdALUCtl(IdALUCtl),
        .IdALUSrc(IdALUSrc), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg), .Flush(Flush), .ExHold(ExHold),
        .MemRegWrite(MemRegWrite), .MemWriteReg(MemWriteReg), .MemALUOut(MemALUOut),
        .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg), .WbData(WbData),
        .Stall(Stall), .ALUCtl(ALUCtl), .A(A), .B(B), .Shamt(Shamt),
        .ExStoreData(ExStoreData), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg),
        .ExWriteReg(ExWriteReg)
    );

    // Reference model: the instruction currently sitting in EX
    typedef struct {
        bit            valid, rw, mr, mw, m2r, alusrc, dk;
        logic [RW-1:0] wr, rs, rt;
        logic [4:0]    shamt;
        logic [3:0]    ctl;
        logic [DW-1:0] rsd, rtd, imm;
    } ex_t;

    ex_t m;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [DW-1:0] fwd_ref(input logic [RW-1:0] idx, input logic [DW-1:0] v);
        if (idx == 0) return v;
        if (MemRegWrite && MemWriteReg == idx) return MemALUOut;
        if (WbRegWrite && WbWriteReg == idx) return WbData;
        return v;
    endfunction

    function automatic bit exp_stall();
        if (reset) return 1'b0;
        return IdValid && !Flush && m.valid && m.mr && (m.wr != 0) &&
               ((m.wr == IdRs) || (m.wr == IdRt));
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] ea, et;
        chk("stall", 32'(Stall), 32'(exp_stall()));
        chk("exvalid", 32'(ExValid), 32'(m.valid));
        chk("regwrite", 32'(ExRegWrite), 32'(m.rw));
        chk("memread", 32'(ExMemRead), 32'(m.mr));
        chk("memwrite", 32'(ExMemWrite), 32'(m.mw));
        chk("memtoreg", 32'(ExMemToReg), 32'(m.m2r));
        chk("aluctl", 32'(ALUCtl), 32'(m.ctl));
        if (m.dk) begin
            ea = fwd_ref(m.rs, m.rsd);
            et = fwd_ref(m.rt, m.rtd);
            chk("A", A, ea);
            chk("B", B, m.alusrc ? m.imm : et);
            chk("storedata", ExStoreData, et);
            chk("shamt", 32'(Shamt), 32'(m.shamt));
            chk("writereg", 32'(ExWriteReg), 32'(m.wr));
        end
    endtask

    task automatic model_edge();
        bit st;
        st = exp_stall();
        if (reset) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.alusrc = 0; m.dk = 1;
            m.wr = 0; m.rs = 0; m.rt = 0; m.shamt = 0; m.ctl = 4'hF;
            m.rsd = 0; m.rtd = 0; m.imm = 0;
        end else if (ExHold) begin
            // frozen
        end else if (Flush || st || !IdValid) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.ctl = 4'hF; m.dk = 0;
        end else begin
            m.valid = 1; m.dk = 1;
            m.rw = IdRegWrite; m.mr = IdMemRead; m.mw = IdMemWrite; m.m2r = IdMemToReg;
            m.alusrc = IdALUSrc; m.wr = IdWriteReg; m.rs = IdRs; m.rt = IdRt;
            m.shamt = IdShamt; m.ctl = IdALUCtl; m.imm = IdImm;
            m.rsd = (WbRegWrite && WbWriteReg != 0 && WbWriteReg == IdRs) ? WbData : IdRsData;
            m.rtd = (WbRegWrite && WbWriteReg != 0 && WbWriteReg == IdRt) ? WbData : IdRtData;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clr_inputs();
        IdValid = 0; IdRsData = 0; IdRtData = 0; IdImm = 0; IdRs = 0; IdRt = 0;
        IdWriteReg = 0; IdShamt = 0; IdALUCtl = 4'b0010; IdALUSrc = 0; IdRegWrite = 0;
        IdMemRead = 0; IdMemWrite = 0; IdMemToReg = 0; Flush = 0; ExHold = 0;
        MemRegWrite = 0; MemWriteReg = 0; MemALUOut = 0;
        WbRegWrite = 0; WbWriteReg = 0; WbData = 0;
    endtask

    task automatic load_to(input logic [RW-1:0] dst);
        clr_inputs();
        IdValid = 1; IdMemRead = 1; IdRegWrite = 1; IdMemToReg = 1;
        IdWriteReg = dst; IdRs = 5'd1; IdALUCtl = 4'b0010;
        tick();
    endtask

    initial begin
        reset = 1;
        clr_inputs();
        @(posedge clk);
        model_edge();
        #1;
        chk("rst_exvalid", 32'(ExValid), 32'd0);
        chk("rst_aluctl", 32'(ALUCtl), 32'hF);
        chk("rst_A", A, 32'd0);
        tick();
        reset = 0;

        // basic capture of an add
        IdValid = 1; IdRs = 5'd1; IdRt = 5'd2; IdRsData = 5; IdRtData = 7;
        IdALUCtl = 4'b0010; IdWriteReg = 5'd3; IdRegWrite = 1;
        tick();
        chk("basic_A", A, 32'd5);
        chk("basic_B", B, 32'd7);
        chk("basic_ctl", 32'(ALUCtl), 32'h2);
        chk("basic_valid", 32'(ExValid), 32'd1);
        chk("basic_stall", 32'(Stall), 32'd0);

        // MEM forwarding and MEM-over-WB priority
        clr_inputs();
        IdValid = 1; IdRs = 5'd8; IdRsData = 32'h11; IdRegWrite = 1; IdWriteReg = 5'd4;
        tick();
        MemRegWrite = 1; MemWriteReg = 5'd8; MemALUOut = 32'h1234;
        #1 chk("memfwd_A", A, 32'h1234);
        WbRegWrite = 1; WbWriteReg = 5'd8; WbData = 32'h9999;
        #1 chk("memprio_A", A, 32'h1234);
        tick();

        // load-use: one bubble, then capture with WB forwarding
        load_to(5'd9);
        IdMemRead = 0; IdMemToReg = 0; IdRs = 5'd9; IdRt = 5'd2; IdRsData = 32'h55;
        IdWriteReg = 5'd10;
        #1 chk("lu_stall", 32'(Stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ExValid), 32'd0);
        chk("lu_bubble_ctl", 32'(ALUCtl), 32'hF);
        MemRegWrite = 1; MemWriteReg = 5'd9; MemALUOut = 32'h100;
        #1 chk("lu_stall_gone", 32'(Stall), 32'd0);
        tick();
        MemRegWrite = 0; WbRegWrite = 1; WbWriteReg = 5'd9; WbData = 32'hABCD;
        #1 chk("lu_wbfwd_A", A, 32'hABCD);
        chk("lu_valid", 32'(ExValid), 32'd1);
        tick();

        // $zero is never forwarded and never stalls
        clr_inputs();
        IdValid = 1; IdRs = 5'd0; IdRsData = 0;
        tick();
        MemRegWrite = 1; MemWriteReg = 5'd0; MemALUOut = 32'hFFFF;
        #1 chk("zero_A", A, 32'd0);
        load_to(5'd0);
        IdMemRead = 0; IdRs = 5'd0;
        #1 chk("zero_stall", 32'(Stall), 32'd0);
        tick();

        // Flush beats Stall
        load_to(5'd9);
        IdMemRead = 0; IdRs = 5'd9; Flush = 1;
        #1 chk("flush_stall", 32'(Stall), 32'd0);
        tick();
        chk("flush_valid", 32'(ExValid), 32'd0);
        chk("flush_ctl", 32'(ALUCtl), 32'hF);

        // ExHold freezes the stage for three cycles
        clr_inputs();
        IdValid = 1; IdRs = 5'd3; IdRsData = 32'h11; IdRt = 5'd4; IdRtData = 32'h22;
        IdALUCtl = 4'b0110;
        tick();
        ExHold = 1; IdRsData = 32'hDEAD; IdRtData = 32'hBEEF; IdALUCtl = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_A", A, 32'h11);
            chk("hold_B", B, 32'h22);
            chk("hold_ctl", 32'(ALUCtl), 32'h6);
            chk("hold_valid", 32'(ExValid), 32'd1);
        end

        // ExHold with a pending load-use keeps Stall asserted
        load_to(5'd9);
        IdMemRead = 0; IdRs = 5'd9; ExHold = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("holdlu_stall", 32'(Stall), 32'd1);
            tick();
        end
        ExHold = 0;
        #1 chk("holdlu_stall_rel", 32'(Stall), 32'd1);
        tick();
        chk("holdlu_bubble", 32'(ExValid), 32'd0);
        tick();
        chk("holdlu_capture", 32'(ExValid), 32'd1);

        // reset mid-stream over a store
        clr_inputs();
        IdValid = 1; IdMemWrite = 1; IdRs = 5'd1; IdRt = 5'd2; IdRsData = 3; IdRtData = 4;
        tick();
        chk("st_memwrite", 32'(ExMemWrite), 32'd1);
        reset = 1;
        tick();
        chk("mrst_valid", 32'(ExValid), 32'd0);
        chk("mrst_memwrite", 32'(ExMemWrite), 32'd0);
        chk("mrst_ctl", 32'(ALUCtl), 32'hF);
        chk("mrst_A", A, 32'd0);
        chk("mrst_B", B, 32'd0);
        tick();
        reset = 0;

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            IdValid     = ($urandom_range(0, 9) < 8);
            Flush       = ($urandom_range(0, 9) == 0);
            ExHold      = ($urandom_range(0, 9) == 0);
            IdRs        = 5'($urandom_range(0, 3));
            IdRt        = 5'($urandom_range(0, 3));
            IdWriteReg  = 5'($urandom_range(0, 3));
            IdRsData    = $urandom;
            IdRtData    = $urandom;
            IdImm       = $urandom;
            IdShamt     = 5'($urandom);
            IdALUCtl    = 4'($urandom);
            IdALUSrc    = 1'($urandom);
            IdRegWrite  = 1'($urandom);
            IdMemRead   = 1'($urandom);
            IdMemWrite  = 1'($urandom);
            IdMemToReg  = 1'($urandom);
            MemRegWrite = 1'($urandom);
            MemWriteReg = 5'($urandom_range(0, 3));
            MemALUOut   = $urandom;
            WbRegWrite  = 1'($urandom);
            WbWriteReg  = 5'($urandom_range(0, 3));
            WbData      = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that feeds the EX-stage ALU.
- Registers decoded operands and controls from ID, and detects load-use hazards, stalling ID and inserting a bubble.
- Applies MEM→EX and WB→EX operand forwarding, then drives the ALU's ALUCtl/A/B/Shamt inputs and carries store data and write-back controls toward EX/MEM.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register index width.
- FWD_EN, 1, 1 enables forwarding; 0 makes A/B use registered operands only (debug).
- NOP_CTL, 4'b1111, ALUCtl value driven during a bubble; it is unused by the ALU, so ALUOut=0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IdValid  in  1  ID holds a real instruction.
- IdRsData, IdRtData  in  DATA_W  register-file read data.
- IdRs, IdRt, IdWriteReg  in  REG_W  source indices; destination already muxed by RegDst.
- IdImm  in  DATA_W  extended immediate.
- IdShamt  in  5  shift amount.
- IdALUCtl  in  4  ALU operation.
- IdALUSrc  in  1  1: B = immediate.
- IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg  in  1  controls.
- Flush  in  1  branch/jump redirect; kills the ID instruction.
- ExHold  in  1  downstream stall; freeze this stage.
- MemRegWrite  in  1  EX/MEM writes a register.
- MemWriteReg  in  REG_W  EX/MEM destination.
- MemALUOut  in  DATA_W  EX/MEM result.
- WbRegWrite  in  1  MEM/WB writes a register.
- WbWriteReg  in  REG_W  MEM/WB destination.
- WbData  in  DATA_W  MEM/WB write data.
- Stall  out  1  hold PC and IF/ID this cycle.
- ALUCtl  out  4  to ALU.
- A, B  out  DATA_W  to ALU.
- Shamt  out  5  to ALU.
- ExStoreData  out  DATA_W  forwarded rt, for sw.
- ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg  out  1  registered controls.
- ExWriteReg  out  REG_W  registered destination.

Behaviour:
Reset:
- All registers clear: ExValid and all Ex* controls = 0; ExWriteReg, Rs, Rt, operands, Imm, Shamt = 0; ALUCtl = NOP_CTL.
- Stall = 0 while reset is high.

Hazard detection (combinational):
- Stall = IdValid & ~Flush & ExValid & ExMemRead & (ExWriteReg != 0) & (ExWriteReg == IdRs | ExWriteReg == IdRt).
- IdRt is compared even for I-type instructions. This is conservative and accepted.

Register update per rising edge, in priority order:
1. reset → reset values.
2. ExHold → all registers keep their values; Stall output is still evaluated.
3. Flush, or Stall, or ~IdValid → bubble: ExValid = 0, RegWrite/MemRead/MemWrite/MemToReg = 0, ALUCtl = NOP_CTL. Data registers may load anything.
4. Otherwise → capture all Id* fields; ExValid = 1.

ID-side bypass at capture:
- If WbRegWrite & WbWriteReg != 0 & WbWriteReg == IdRs, the captured rs operand = WbData; same rule for rt.
- The register file therefore need not be write-before-read.

Forwarding (combinational on registered rs/rt, only when FWD_EN = 1):
- fwdRs = MemALUOut if MemRegWrite & MemWriteReg != 0 & MemWriteReg == ExRs.
- else WbData under the same condition using WbRegWrite/WbWriteReg.
- else the registered operand.
- MEM has priority over WB. Register 0 is never forwarded. fwdRt is computed the same way.

Outputs:
- A = fwdRs.
- B = ExALUSrc ? ExImm : fwdRt.
- ExStoreData = fwdRt always.
- Shamt and ALUCtl come straight from registers.

Latency: one cycle from ID to the ALU inputs. A load-use hazard costs exactly one bubble.

Flush and Stall in the same cycle: Flush wins, Stall = 0, bubble inserted.

ExHold with a pending load-use: Stall stays asserted each held cycle. No instruction is lost or duplicated.

Decomposition:
- Shared package mips_pkg holds the ALU_* opcode constants (ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, SLT 4'b0111, SLL 4'b1001, SRL 4'b1010, LUI 4'b1000, XOR 4'b1011, NOP 4'b1111), plus DATA_W/REG_W defaults.
- One sub-module, fwd_mux: a per-operand forwarding comparator/mux, instantiated twice (rs and rt).
- Hazard detection stays inline.

Test Plan:
- Basic capture: ID add, IdRsData=5, IdRtData=7, no hazards → next cycle A=5, B=7, ALUCtl=4'b0010, ExValid=1, Stall=0.
- MEM forwarding: EX/MEM MemRegWrite=1, MemWriteReg=8, MemALUOut=0x1234, registered Rs=8 → A=0x1234. Repeat with WbWriteReg=8 also matching and WbData=0x9999 → A still 0x1234.
- Load-use: EX holds lw to $9, ID reads $9 → Stall=1 for one cycle, next-cycle ExValid=0, ALUCtl=4'b1111. Following cycle the instruction captures, with A=WbData via forwarding.
- $zero guard: MemRegWrite=1, MemWriteReg=0, MemALUOut=0xFFFF, ExRs=0, registered operand 0 → A=0. A load to $0 followed by a read of $0 → Stall=0.
- Flush vs stall: Flush=1 in the same cycle as a load-use match → Stall=0, bubble. ExHold=1 for 3 cycles → all outputs unchanged.
- Reset mid-stream: assert reset while ExValid=1 and ExMemWrite=1 → next edge ExValid=0, ExMemWrite=0, ALUCtl=4'b1111, A=B=0.
